// File: rtl/keypad_debounce.sv
// ---------------------------------------------------------------------------
// keypad_debounce
// Per-key input conditioner between the raw keypad pins and the game core.
// Each key is synchronised with two flops. Its contact bounce is filtered by
// a stable-cycle counter. The key then drives a clean level plus one-cycle
// press and release pulses, so the core sees exactly one press per physical
// press.
//
// Parameters
//   N_KEYS     number of keys (bit i of every vector is key i)
//   DB_CYCLES  consecutive stable synchronised cycles needed to accept a level
//   CNT_W      debounce counter width (DB_CYCLES <= 2**CNT_W - 1)
//
// Ports
//   CLK          in   system clock, rising edge
//   RESET        in   asynchronous active-high reset
//   keypad_raw   in   raw key levels (1 = pressed), asynchronous to CLK
//   key_level    out  debounced level per key
//   key_press    out  one-cycle pulse on debounced 0->1
//   key_release  out  one-cycle pulse on debounced 1->0
//   any_press    out  OR of key_press
// ---------------------------------------------------------------------------
module keypad_debounce #(
  parameter int N_KEYS    = 8,
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] keypad_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              any_press
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  logic [N_KEYS-1:0] r_raw_p0;
  logic [N_KEYS-1:0] r_raw_p1;
  logic [CNT_W-1:0]  r_cnt [N_KEYS];
  logic [N_KEYS-1:0] r_level;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_raw_p0  <= '0;
      r_raw_p1  <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      // stage p0/p1: two-flop synchroniser for the asynchronous pins
      r_raw_p0 <= keypad_raw;
      r_raw_p1 <= r_raw_p0;

      // debounce stage: count consecutive cycles that disagree with the
      // accepted level; any agreeing cycle restarts the window
      for (int i = 0; i < N_KEYS; i++) begin
        r_press[i]   <= 1'b0;
        r_release[i] <= 1'b0;
        if (r_raw_p1[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_CNT_MAX) begin
          // accept the new level; pulses ride on the same edge
          r_level[i]   <= r_raw_p1[i];
          r_press[i]   <= r_raw_p1[i];
          r_release[i] <= ~r_raw_p1[i];
          r_cnt[i]     <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + LP_CNT_ONE;
        end
      end
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  // OR of registered pulses: still no path from the pins to any output
  assign any_press   = |r_press;

endmodule

// File: tb/tb_keypad_debounce.sv
module tb_keypad_debounce;
  localparam int N  = 8;
  localparam int DB = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [N-1:0] keypad_raw = '0;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic         any_press;

  always #5 CLK = ~CLK;

  keypad_debounce #(.N_KEYS(N), .DB_CYCLES(DB), .CNT_W(16)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .keypad_raw  (keypad_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .any_press   (any_press)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a key's level flips when the last DB synchronised
  // samples all disagree with it. The synchronised sample seen at edge n
  // is the raw value sampled at edge n-2. The model therefore keeps the raw
  // samples and looks at the window raw[n-1-DB] .. raw[n-2].
  logic [N-1:0] hist [$];
  logic [N-1:0] exp_level, exp_press, exp_release;

  task automatic check8(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_level   = '0;
    exp_press   = '0;
    exp_release = '0;
    hist.delete();
    // samples before reset release look like 0 (synchroniser cleared)
    for (int i = 0; i <= DB; i++) hist.push_back('0);
  endtask

  task automatic model_edge(input logic [N-1:0] raw);
    exp_press   = '0;
    exp_release = '0;
    for (int k = 0; k < N; k++) begin
      logic all1, all0;
      all1 = 1'b1;
      all0 = 1'b1;
      for (int j = hist.size() - 1 - DB; j <= hist.size() - 2; j++) begin
        all1 &= hist[j][k];
        all0 &= ~hist[j][k];
      end
      if (all1 && !exp_level[k]) begin
        exp_level[k] = 1'b1;
        exp_press[k] = 1'b1;
      end else if (all0 && exp_level[k]) begin
        exp_level[k]   = 1'b0;
        exp_release[k] = 1'b1;
      end
    end
    hist.push_back(raw);
    if (hist.size() > DB + 1) void'(hist.pop_front());
  endtask

  task automatic check_all(input string tag);
    check8({tag, "_level"},   key_level,   exp_level);
    check8({tag, "_press"},   key_press,   exp_press);
    check8({tag, "_release"}, key_release, exp_release);
    check1({tag, "_any"},     any_press,   |exp_press);
  endtask

  task automatic tick(input logic [N-1:0] raw, input string tag);
    @(negedge CLK);
    keypad_raw = raw;
    @(posedge CLK);
    model_edge(raw);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [N-1:0] r;

    // reset held: outputs stay 0 even with keys pressed
    keypad_raw = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      #1;
      check8("rst_level", key_level, 8'h00);
      check8("rst_press", key_press, 8'h00);
      check1("rst_any", any_press, 1'b0);
    end
    keypad_raw = 8'h00;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();

    // T1: raw[3] rises and holds; press on the 6th edge
    for (int i = 1; i <= 8; i++) begin
      tick(8'h08, "T1");
      if (i == 6) check8("T1_press_edge", key_press, 8'h08);
      if (i == 7) check8("T1_press_gone", key_press, 8'h00);
    end
    // T4: release of key 3
    for (int i = 1; i <= 8; i++) begin
      tick(8'h00, "T4");
      if (i == 6) check8("T4_release_edge", key_release, 8'h08);
    end

    // T2: raw[0] toggling every 2 cycles never gets through
    r = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) r[0] = ~r[0];
      tick(r, "T2");
      check8("T2_level", key_level, 8'h00);
    end
    for (int i = 0; i < 8; i++) tick(8'h00, "T2z");

    // T3: keys 0 and 7 together
    for (int i = 1; i <= 8; i++) begin
      tick(8'h81, "T3");
      if (i == 6) begin
        check8("T3_press", key_press, 8'h81);
        check1("T3_any_hi", any_press, 1'b1);
      end
      if (i == 7) check1("T3_any_lo", any_press, 1'b0);
    end
    for (int i = 0; i < 8; i++) tick(8'h00, "T3z");

    // T5: 3-cycle glitch rejected, 4-cycle hold accepted
    for (int i = 0; i < 3; i++) tick(8'h20, "T5g");
    for (int i = 0; i < 6; i++) begin
      tick(8'h00, "T5q");
      check8("T5_glitch_level", key_level, 8'h00);
    end
    for (int i = 0; i < 4; i++) tick(8'h20, "T5h");
    for (int i = 1; i <= 8; i++) begin
      tick(8'h00, "T5r");
      if (i == 2) check8("T5_hold_level", key_level, 8'h20);
    end
    for (int i = 0; i < 4; i++) tick(8'h00, "T5z");

    // T6: asynchronous reset mid-count with raw[1] held
    for (int i = 0; i < 3; i++) tick(8'h02, "T6a");
    #1;
    RESET = 1'b1;
    model_reset();
    #1;
    check8("T6_rst_level", key_level, 8'h00);
    check8("T6_rst_press", key_press, 8'h00);
    check1("T6_rst_any", any_press, 1'b0);
    RESET = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(8'h02, "T6b");
      if (i == 5) check8("T6_no_early", key_press, 8'h00);
      if (i == 6) check8("T6_press", key_press, 8'h02);
    end

    // randomized: each key flips with probability about 1/4 per cycle
    r = 8'h02;
    for (int i = 0; i < 400; i++) begin
      r = r ^ (8'($urandom) & 8'($urandom));
      tick(r, "RND");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
